// File: rtl/packer_pkg.sv
// Shared definitions for the byte lane packer: default geometry, lane mask
// and word types at the default geometry, and the accumulator state enum.
package packer_pkg;

  localparam int BYTE_W_DEF  = 8;
  localparam int N_LANES_DEF = 2;

  typedef logic [N_LANES_DEF-1:0]            lane_mask_t;
  typedef logic [N_LANES_DEF*BYTE_W_DEF-1:0] word_t;

  typedef enum logic {
    EMPTY = 1'b0,
    PART  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/packer_out_reg.sv
// Valid/ready output holding register for the byte lane packer.
// Loads a packed word and its byte enables, holds them while the consumer
// stalls, and drops valid once the word is consumed with nothing new behind it.
module packer_out_reg
  import packer_pkg::*;
#(
  parameter int W = N_LANES_DEF * BYTE_W_DEF,
  parameter int N = N_LANES_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_d,
  input  logic [N-1:0] load_be,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_d,
  output logic [N-1:0] out_byteena
);

  // Load has priority so a consume and a new word on the same edge keep valid high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid   <= 1'b0;
      out_d       <= '0;
      out_byteena <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_d       <= load_d;
      out_byteena <= load_be;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_lane_packer.sv
// Byte lane packer: collects a valid/ready byte stream into N_LANES-byte
// words with a per-byte enable mask for a byte-enabled write port.
// Words close when the top lane fills, on in_last, on flush, or (when the
// PACKER_TIMEOUT_EN macro is defined) after TIMEOUT_CYCLES idle cycles.
module byte_lane_packer
  import packer_pkg::*;
#(
  parameter int N_LANES        = N_LANES_DEF,
  parameter int BYTE_W         = BYTE_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_LANES*BYTE_W-1:0] out_d,
  output logic [N_LANES-1:0]        out_byteena
);

  localparam int               PTR_W     = $clog2(N_LANES);
  localparam int               WORD_W    = N_LANES * BYTE_W;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(N_LANES - 1);

  acc_state_e          state_q, state_n;
  logic [PTR_W-1:0]    ptr_q, ptr_n;
  logic [WORD_W-1:0]   acc_data_q, acc_data_n;
  logic [N_LANES-1:0]  acc_mask_q, acc_mask_n;
  logic                flush_pend_q, flush_pend_n;

  logic                slot_free;
  logic                accept;
  logic                emit_cond;
  logic                emit;
  logic                timeout_flush;
  logic [WORD_W-1:0]   merged_data;
  logic [N_LANES-1:0]  merged_mask;

  // The last lane can only be taken when the output slot can receive the word it completes.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free || (ptr_q != LAST_LANE);
  assign accept    = in_valid && in_ready;

`ifdef PACKER_TIMEOUT_EN
  localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_cnt_q;
  logic            idle_now;

  assign idle_now      = (state_q == PART) && !accept;
  assign timeout_flush = idle_now && (idle_cnt_q == TO_MAX);

  // Count idle cycles of a partial word; the cycle that would reach the limit raises the flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_q <= '0;
    end else if (accept || emit) begin
      idle_cnt_q <= '0;
    end else if (idle_now && (idle_cnt_q != TO_MAX)) begin
      idle_cnt_q <= idle_cnt_q + TO_W'(1);
    end
  end
`else
  // No idle timer in this build: partial words wait for in_last or flush.
  assign timeout_flush = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // Merge this cycle's byte, decide whether a word closes, and compute the next accumulator.
  always_comb begin
    merged_data  = acc_data_q;
    merged_mask  = acc_mask_q;
    state_n      = state_q;
    ptr_n        = ptr_q;
    acc_data_n   = acc_data_q;
    acc_mask_n   = acc_mask_q;
    flush_pend_n = flush_pend_q;

    if (accept) begin
      merged_data[ptr_q*BYTE_W +: BYTE_W] = in_data;
      merged_mask[ptr_q]                  = 1'b1;
    end

    emit_cond = (accept && (ptr_q == LAST_LANE))
             || (accept && in_last)
             || ((flush || flush_pend_q || timeout_flush) && ((state_q == PART) || accept));
    emit      = emit_cond && slot_free;

    if (emit) begin
      state_n      = EMPTY;
      ptr_n        = '0;
      acc_data_n   = '0;
      acc_mask_n   = '0;
      flush_pend_n = 1'b0;
    end else begin
      if (accept) begin
        state_n    = PART;
        ptr_n      = ptr_q + PTR_W'(1);
        acc_data_n = merged_data;
        acc_mask_n = merged_mask;
      end
      if (emit_cond) begin
        flush_pend_n = 1'b1;
      end
    end
  end

  // Accumulator state register; reset discards any partial word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= EMPTY;
      ptr_q        <= '0;
      acc_data_q   <= '0;
      acc_mask_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      ptr_q        <= ptr_n;
      acc_data_q   <= acc_data_n;
      acc_mask_q   <= acc_mask_n;
      flush_pend_q <= flush_pend_n;
    end
  end

  packer_out_reg #(
    .W (WORD_W),
    .N (N_LANES)
  ) u_out_reg (
    .clk         (clk),
    .resetn      (resetn),
    .load        (emit),
    .load_d      (merged_data),
    .load_be     (merged_mask),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_d       (out_d),
    .out_byteena (out_byteena)
  );

endmodule

// File: tb/tb_byte_lane_packer.sv
// Testbench for byte_lane_packer (N_LANES=2, BYTE_W=8, TIMEOUT_CYCLES=4).
// Directed scenarios plus a randomized run against a queue-based word model.
// Behaviour of the idle timeout follows the PACKER_TIMEOUT_EN macro.
module tb_byte_lane_packer;

  localparam int N_LANES = 2;
  localparam int BYTE_W  = 8;
  localparam int TIMEOUT = 4;
  localparam int WORD_W  = N_LANES * BYTE_W;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_d;
  logic [N_LANES-1:0] out_byteena;

  int checks = 0;
  int passes = 0;

  // Reference model: bytes of the open word, pending-close flag, output slot, idle count
  logic [BYTE_W-1:0]  cur[$];
  bit                 m_pend;
  bit                 m_valid;
  logic [WORD_W-1:0]  m_d;
  logic [N_LANES-1:0] m_be;
  int                 m_idle;

  // Values observed at the falling edge and the model's prediction for that cycle
  logic               obs_rdy, obs_valid;
  logic [WORD_W-1:0]  obs_d;
  logic [N_LANES-1:0] obs_be;
  logic               exp_rdy, exp_valid;
  logic [WORD_W-1:0]  exp_d;
  logic [N_LANES-1:0] exp_be;

  always #5 clk = ~clk;

  byte_lane_packer #(
    .N_LANES        (N_LANES),
    .BYTE_W         (BYTE_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_d       (out_d),
    .out_byteena (out_byteena)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish, got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    cur.delete();
    m_pend  = 0;
    m_valid = 0;
    m_d     = '0;
    m_be    = '0;
    m_idle  = 0;
  endtask

  task automatic drive(input bit v, input logic [BYTE_W-1:0] d, input bit l, input bit f);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    flush    = f;
  endtask

  // One clock: sample at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    bit sf, rdy, acc, emitc, tof;
    @(negedge clk);
    obs_rdy   = in_ready;
    obs_valid = out_valid;
    obs_d     = out_d;
    obs_be    = out_byteena;
    sf        = !m_valid || out_ready;
    rdy       = sf || (cur.size() != N_LANES - 1);
    exp_rdy   = rdy;
    exp_valid = m_valid;
    exp_d     = m_d;
    exp_be    = m_be;
    acc       = in_valid && rdy;
    tof       = 0;
`ifdef PACKER_TIMEOUT_EN
    if (cur.size() > 0 && !acc && (m_idle + 1 >= TIMEOUT)) tof = 1;
`endif
    if (acc) cur.push_back(in_data);
    emitc = (acc && cur.size() == N_LANES) || (acc && in_last)
         || ((flush || m_pend || tof) && cur.size() > 0);
    if (emitc && sf) begin
      m_valid = 1;
      m_d     = '0;
      m_be    = '0;
      foreach (cur[i]) begin
        m_d[i*BYTE_W +: BYTE_W] = cur[i];
        m_be[i]                 = 1'b1;
      end
      cur.delete();
      m_pend = 0;
      m_idle = 0;
    end else begin
      if (out_ready) m_valid = 0;
      if (emitc) m_pend = 1;
      if (acc) m_idle = 0;
      else if (cur.size() > 0) m_idle++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    out_ready = 1'b0;
    drive(0, 8'h00, 0, 0);
    #3;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%b want=0", out_valid); else passes++;
    checks++; if (out_d !== 16'h0000) $display("[TB] FAIL reset_d got=%h want=0000", out_d); else passes++;
    checks++; if (out_byteena !== 2'b00) $display("[TB] FAIL reset_be got=%b want=00", out_byteena); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); else passes++;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    drive(1, 8'h34, 0, 0); step();
    drive(1, 8'h12, 0, 0); step();
    checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL full_word_early_valid got=%b want=0", obs_valid); else passes++;
    drive(0, 8'h00, 0, 0); step();
    checks++; if (obs_valid !== 1'b1) $display("[TB] FAIL full_word_valid got=%b want=1", obs_valid); else passes++;
    checks++; if (obs_d !== 16'h1234) $display("[TB] FAIL full_word_d got=%h want=1234", obs_d); else passes++;
    checks++; if (obs_be !== 2'b11) $display("[TB] FAIL full_word_be got=%b want=11", obs_be); else passes++;
  endtask

  task automatic test_last();
    out_ready = 1'b1;
    drive(1, 8'hAB, 1, 0); step();
    drive(0, 8'h00, 0, 0); step();
    checks++; if (obs_valid !== 1'b1) $display("[TB] FAIL last_valid got=%b want=1", obs_valid); else passes++;
    checks++; if (obs_d !== 16'h00AB) $display("[TB] FAIL last_d got=%h want=00ab", obs_d); else passes++;
    checks++; if (obs_be !== 2'b01) $display("[TB] FAIL last_be got=%b want=01", obs_be); else passes++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1, 8'h34, 0, 0); step();
    drive(1, 8'h12, 0, 0); step();
    drive(1, 8'h56, 0, 0); step();
    checks++; if (obs_rdy !== 1'b1) $display("[TB] FAIL bp_accept_56 got=%b want=1", obs_rdy); else passes++;
    drive(1, 8'h78, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (obs_rdy !== 1'b0) $display("[TB] FAIL bp_block_78 got=%b want=0", obs_rdy); else passes++;
      checks++; if (obs_d !== 16'h1234) $display("[TB] FAIL bp_hold_d got=%h want=1234", obs_d); else passes++;
    end
    out_ready = 1'b1;
    step();
    checks++; if (obs_rdy !== 1'b1) $display("[TB] FAIL bp_release_78 got=%b want=1", obs_rdy); else passes++;
    drive(0, 8'h00, 0, 0); step();
    checks++; if (obs_d !== 16'h7856) $display("[TB] FAIL bp_next_d got=%h want=7856", obs_d); else passes++;
    checks++; if (obs_be !== 2'b11) $display("[TB] FAIL bp_next_be got=%b want=11", obs_be); else passes++;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1, 8'h01, 0, 0); step();
    drive(1, 8'h02, 0, 0); step();
    drive(1, 8'hCD, 0, 0); step();
    drive(0, 8'h00, 0, 1); step();
    drive(0, 8'h00, 0, 0); step();
    checks++; if (obs_d !== 16'h0201) $display("[TB] FAIL flush_hold_d got=%h want=0201", obs_d); else passes++;
    out_ready = 1'b1;
    step();
    step();
    checks++; if (obs_valid !== 1'b1) $display("[TB] FAIL flush_valid got=%b want=1", obs_valid); else passes++;
    checks++; if (obs_d !== 16'h00CD) $display("[TB] FAIL flush_d got=%h want=00cd", obs_d); else passes++;
    checks++; if (obs_be !== 2'b01) $display("[TB] FAIL flush_be got=%b want=01", obs_be); else passes++;
    // A cleared pending flag means a new single byte is not closed early
    drive(1, 8'hEE, 0, 0); step();
    drive(0, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL flush_pend_cleared got=%b want=0", obs_valid); else passes++;
    end
    drive(1, 8'hFF, 1, 0); step();
    drive(0, 8'h00, 0, 0); step();
    checks++; if (obs_d !== 16'hFFEE) $display("[TB] FAIL flush_after_d got=%h want=ffee", obs_d); else passes++;
    // Flush of an empty accumulator does nothing
    drive(0, 8'h00, 0, 1); step();
    drive(0, 8'h00, 0, 0); step();
    checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL flush_empty got=%b want=0", obs_valid); else passes++;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(1, 8'h01, 0, 0); step();
    drive(1, 8'h02, 0, 0); step();
    drive(1, 8'h99, 0, 0); step();
    drive(0, 8'h00, 0, 0);
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midreset_valid got=%b want=0", out_valid); else passes++;
    checks++; if (out_byteena !== 2'b00) $display("[TB] FAIL midreset_be got=%b want=00", out_byteena); else passes++;
    model_reset();
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    drive(1, 8'h11, 0, 0); step();
    drive(1, 8'h22, 0, 0); step();
    drive(0, 8'h00, 0, 0); step();
    checks++; if (obs_d !== 16'h2211) $display("[TB] FAIL midreset_d got=%h want=2211", obs_d); else passes++;
    checks++; if (obs_be !== 2'b11) $display("[TB] FAIL midreset_be2 got=%b want=11", obs_be); else passes++;
  endtask

  task automatic test_timeout();
    out_ready = 1'b1;
    drive(1, 8'h5A, 0, 0); step();
    drive(0, 8'h00, 0, 0);
`ifdef PACKER_TIMEOUT_EN
    for (int i = 1; i <= TIMEOUT; i++) begin
      step();
      checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL timeout_early got=%b want=0 idle=%0d", obs_valid, i); else passes++;
    end
    step();
    checks++; if (obs_valid !== 1'b1) $display("[TB] FAIL timeout_valid got=%b want=1", obs_valid); else passes++;
    checks++; if (obs_d !== 16'h005A) $display("[TB] FAIL timeout_d got=%h want=005a", obs_d); else passes++;
    checks++; if (obs_be !== 2'b01) $display("[TB] FAIL timeout_be got=%b want=01", obs_be); else passes++;
`else
    begin
      int seen = 0;
      for (int i = 0; i < 100; i++) begin
        step();
        if (obs_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) $display("[TB] FAIL no_timeout got=%0d valid cycles want=0", seen); else passes++;
    end
    drive(0, 8'h00, 0, 1); step();
    drive(0, 8'h00, 0, 0); step();
    checks++; if (obs_d !== 16'h005A) $display("[TB] FAIL no_timeout_flush_d got=%h want=005a", obs_d); else passes++;
`endif
    step();
  endtask

  task automatic test_back_to_back();
    int words = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1, 8'($urandom), 0, 0);
      else drive(0, 8'h00, 0, 0);
      step();
      if (obs_valid === 1'b1) words++;
      if (i < 8) begin
        checks++; if (obs_rdy !== 1'b1) $display("[TB] FAIL b2b_ready got=%b want=1 i=%0d", obs_rdy, i); else passes++;
      end
      checks++; if (obs_valid !== exp_valid) $display("[TB] FAIL b2b_valid got=%b want=%b i=%0d", obs_valid, exp_valid, i); else passes++;
      if (exp_valid) begin
        checks++; if (obs_d !== exp_d) $display("[TB] FAIL b2b_d got=%h want=%h i=%0d", obs_d, exp_d, i); else passes++;
      end
    end
    checks++; if (words != 4) $display("[TB] FAIL b2b_words got=%0d want=4", words); else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      out_ready = 1'($urandom_range(0, 1));
      step();
      checks++; if (obs_rdy !== exp_rdy) $display("[TB] FAIL rand_ready got=%b want=%b i=%0d", obs_rdy, exp_rdy, i); else passes++;
      checks++; if (obs_valid !== exp_valid) $display("[TB] FAIL rand_valid got=%b want=%b i=%0d", obs_valid, exp_valid, i); else passes++;
      if (exp_valid) begin
        checks++; if (obs_d !== exp_d) $display("[TB] FAIL rand_d got=%h want=%h i=%0d", obs_d, exp_d, i); else passes++;
        checks++; if (obs_be !== exp_be) $display("[TB] FAIL rand_be got=%b want=%b i=%0d", obs_be, exp_be, i); else passes++;
      end
    end
  endtask

  initial begin
    $display("[TB] byte_lane_packer bench start");
    test_reset();
    test_full_word();
    test_last();
    test_backpressure();
    test_flush();
    test_mid_reset();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
